// File: rtl/fft_pkg.sv
// Shared types and helpers for the radix-2 FFT controller and its datapath.
package fft_pkg;

  localparam int FFT_BITS = 16;

  typedef struct packed {
    logic signed [FFT_BITS-1:0] re;
    logic signed [FFT_BITS-1:0] im;
  } complex_t;

  typedef struct packed {
    logic signed [2*FFT_BITS-1:0] re;
    logic signed [2*FFT_BITS-1:0] im;
  } complex_product_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_COMPUTE,
    ST_DRAIN,
    ST_UNLOAD
  } fft_state_e;

  // Reverses the low 'bits' bits of v; bits above 'bits' come back as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] v, input int bits);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < bits) r[i] = v[bits-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_rad2_ctrl_if.sv
// Load, unload and butterfly-issue signals of the FFT controller.
// Handshakes: a transfer happens on a rising clk edge where valid and ready are both high;
// valid never waits on ready, and the source holds its address stable until the transfer.
interface fft_rad2_ctrl_if #(
  parameter int INDEX_BITS = 3
);
  logic                  in_valid;
  logic                  in_ready;
  logic                  wr_en;
  logic [INDEX_BITS-1:0] wr_addr;
  logic                  bf_issue;
  logic [INDEX_BITS-1:0] bf_addr_a;
  logic [INDEX_BITS-1:0] bf_addr_b;
  logic [INDEX_BITS-2:0] bf_tw_idx;
  logic                  bf_wb;
  logic [INDEX_BITS-1:0] wb_addr_a;
  logic [INDEX_BITS-1:0] wb_addr_b;
  logic                  out_valid;
  logic                  out_ready;
  logic [INDEX_BITS-1:0] rd_addr;

  modport master (
    input  in_valid, out_ready,
    output in_ready, wr_en, wr_addr, bf_issue, bf_addr_a, bf_addr_b, bf_tw_idx,
           bf_wb, wb_addr_a, wb_addr_b, out_valid, rd_addr
  );

  modport slave (
    output in_valid, out_ready,
    input  in_ready, wr_en, wr_addr, bf_issue, bf_addr_a, bf_addr_b, bf_tw_idx,
           bf_wb, wb_addr_a, wb_addr_b, out_valid, rd_addr
  );
endinterface

// File: rtl/fft_addr_gen.sv
// Combinational in-place DIT butterfly addressing: (stage, bfly) -> operand pair and twiddle index.
module fft_addr_gen #(
  parameter int INDEX_BITS = 3
) (
  input  logic [INDEX_BITS-1:0] stage,
  input  logic [INDEX_BITS-2:0] bfly,
  output logic [INDEX_BITS-1:0] addr_a,
  output logic [INDEX_BITS-1:0] addr_b,
  output logic [INDEX_BITS-2:0] tw_idx
);
  localparam int BW = INDEX_BITS - 1;

  logic [BW-1:0] pos_mask;
  logic [BW-1:0] pos;
  logic [BW-1:0] grp;

  always_comb begin
    // At the last stage the shift overflows to zero and the mask becomes all ones.
    pos_mask = (BW'(1) << stage) - BW'(1);
    pos      = bfly & pos_mask;
    grp      = bfly >> stage;
    addr_a   = ({grp, 1'b0} << stage) | {1'b0, pos};
    addr_b   = addr_a | (INDEX_BITS'(1) << stage);
    tw_idx   = pos << (INDEX_BITS'(INDEX_BITS - 1) - stage);
  end
endmodule

// File: rtl/fft_rad2_ctrl.sv
// Sequencer for an in-place radix-2 DIT FFT: bit-reversed load, staged butterfly issue
// with delayed write-back, natural-order unload.
module fft_rad2_ctrl
  import fft_pkg::*;
#(
  parameter int N          = 8,
  parameter int INDEX_BITS = $clog2(N),
  parameter int BF_LAT     = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  fft_rad2_ctrl_if.master       bus,
  output logic [INDEX_BITS-1:0] stage,
  output logic                  busy,
  output logic                  done,
  output fft_state_e            state_dbg
);
  localparam int BW = INDEX_BITS - 1;
  localparam int DW = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;

  fft_state_e state_q, state_d;
  logic [INDEX_BITS-1:0] load_cnt, out_cnt, stage_q;
  logic [BW-1:0]         bfly_cnt;
  logic [DW-1:0]         drain_cnt;
  logic                  done_q;
  logic [BF_LAT-1:0]                 pipe_v;
  logic [BF_LAT-1:0][INDEX_BITS-1:0] pipe_a, pipe_b;
  logic [INDEX_BITS-1:0] ag_a, ag_b;
  logic [BW-1:0]         ag_tw;
  logic load_last, bfly_last, drain_last, last_stage, out_fire, frame_end;

  fft_addr_gen #(.INDEX_BITS(INDEX_BITS)) u_addr_gen (
    .stage (stage_q),
    .bfly  (bfly_cnt),
    .addr_a(ag_a),
    .addr_b(ag_b),
    .tw_idx(ag_tw)
  );

  assign bus.in_ready  = !reset && (state_q == ST_IDLE || state_q == ST_LOAD);
  assign bus.wr_en     = bus.in_valid && bus.in_ready;
  assign bus.wr_addr   = INDEX_BITS'(bitrev(32'(load_cnt), INDEX_BITS));
  assign bus.bf_issue  = (state_q == ST_COMPUTE);
  assign bus.bf_addr_a = bus.bf_issue ? ag_a : '0;
  assign bus.bf_addr_b = bus.bf_issue ? ag_b : '0;
  assign bus.bf_tw_idx = bus.bf_issue ? ag_tw : '0;
  assign bus.bf_wb     = pipe_v[BF_LAT-1];
  assign bus.wb_addr_a = pipe_a[BF_LAT-1];
  assign bus.wb_addr_b = pipe_b[BF_LAT-1];
  assign bus.out_valid = (state_q == ST_UNLOAD);
  assign bus.rd_addr   = out_cnt;

  assign stage     = stage_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign state_dbg = state_q;

  assign load_last  = bus.wr_en && (load_cnt == INDEX_BITS'(N - 1));
  assign bfly_last  = (state_q == ST_COMPUTE) && (bfly_cnt == BW'(N / 2 - 1));
  assign drain_last = (state_q == ST_DRAIN) && (drain_cnt == DW'(BF_LAT - 1));
  assign last_stage = (stage_q == INDEX_BITS'(INDEX_BITS - 1));
  assign out_fire   = bus.out_valid && bus.out_ready;
  assign frame_end  = out_fire && (out_cnt == INDEX_BITS'(N - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (bus.wr_en) state_d = ST_LOAD;
      ST_LOAD:    if (load_last) state_d = ST_COMPUTE;
      ST_COMPUTE: if (bfly_last) state_d = ST_DRAIN;
      ST_DRAIN:   if (drain_last) state_d = last_stage ? ST_UNLOAD : ST_COMPUTE;
      ST_UNLOAD:  if (frame_end) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      load_cnt  <= '0;
      bfly_cnt  <= '0;
      drain_cnt <= '0;
      stage_q   <= '0;
      out_cnt   <= '0;
      done_q    <= 1'b0;
      pipe_v    <= '0;
      pipe_a    <= '0;
      pipe_b    <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= frame_end;
      if (bus.wr_en) load_cnt <= load_cnt + 1'b1;
      // Counters wrap naturally to zero at the end of their phase.
      if (state_q == ST_COMPUTE) bfly_cnt <= bfly_cnt + 1'b1;
      drain_cnt <= (state_q == ST_DRAIN && !drain_last) ? drain_cnt + 1'b1 : '0;
      if (load_last || frame_end) stage_q <= '0;
      else if (drain_last && !last_stage) stage_q <= stage_q + 1'b1;
      if (out_fire) out_cnt <= out_cnt + 1'b1;
      pipe_v[0] <= bus.bf_issue;
      pipe_a[0] <= bus.bf_addr_a;
      pipe_b[0] <= bus.bf_addr_b;
      for (int i = 1; i < BF_LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_a[i] <= pipe_a[i-1];
        pipe_b[i] <= pipe_b[i-1];
      end
    end
  end
endmodule
